conv_psum_acc: RTL and testbench
================================

# conv_psum_acc

Partial-sum accumulator and requantizer directly downstream of the 25-tap systolic convolution chain. It consumes one full-precision convolution result per accepted beat and accumulates results for the same output pixel across successive input-channel passes in an internal per-pixel buffer. On the last channel pass it adds bias, applies optional ReLU, arithmetic-shifts and saturates to the quantized width, and presents the pixel on a valid/ready output toward the output buffer writer.

## Interface
- DW, 32: width of incoming convolution result, equals `DATA_BUS_WIDTH
- QW, 8: width of quantized output, equals `QDATA_BUS_WIDTH
- DEPTH, 64: number of psum entries (max output pixels per tile)
- AW, $clog2(DEPTH): pixel address width
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- clear  input  1  synchronous abort: address to 0, FSM to IDLE, output register emptied
- pix_num  input  AW+1  pixels per pass, legal 1..DEPTH, held stable while busy
- bias  input  DW  signed bias, sampled at pass start
- shift  input  5  right-shift amount 0..31, sampled at pass start
- relu_en  input  1  clamp negatives to 0, sampled at pass start
- in_valid  input  1  in_data valid (driven by controller aligned to conv chain output)
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  DW  signed convolution result
- in_first  input  1  pass is first input channel (overwrite psum), sampled at pass start
- in_last  input  1  pass is last input channel (emit output), sampled at pass start
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts
- out_data  output  QW  signed quantized pixel
- busy  output  1  FSM in RUN
- done  output  1  one-cycle pulse when a last-channel pass's final pixel is emitted

## Operation
- FSM IDLE/RUN. IDLE -> RUN on first accepted beat; at that beat latch in_first, in_last, bias, shift, relu_en; later changes ignored until next pass. RUN -> IDLE on the accepted beat with addr == pix_num-1.
- Address counter addr: 0 on reset/clear; +1 per accepted beat; wraps to 0 after pix_num-1.
- Per accepted beat at addr a: sum = (first ? 0 : psum[a]) + in_data, DW-bit two's-complement wrap, no saturation.
- Not last pass: psum[a] <= sum; no output.
- Last pass: psum[a] unchanged; t = sum + bias evaluated at DW+1 bits; if relu_en and t<0 then t=0; r = t >>> shift (arithmetic, floor toward -inf); out_data <= saturate(r) to [-2^(QW-1), 2^(QW-1)-1]; out_valid <= 1.
- Output register single-entry: in_ready = !out_valid || out_ready (non-last passes never stall on output... still gated identically for simplicity).
- psum array not reset; contents undefined until written by a first pass.
- clear has priority over a same-cycle beat: beat dropped, addr 0, out_valid 0, done 0.

## Timing
- Reset values: in_ready 1, out_valid 0, out_data 0, busy 0, done 0, addr 0, FSM IDLE.
- Latency: accepted last-pass beat in cycle N -> out_valid/out_data in cycle N+1.
- out_data held stable while out_valid && !out_ready; a new beat may be accepted in the same cycle out_ready consumes (full throughput, 1 beat/cycle).
- done asserted cycle N+1 together with out_valid of the final pixel of a last pass; 1 cycle wide regardless of out_ready.
- busy deasserts cycle after the final beat of a pass is accepted.
- Async rst mid-pass: all outputs return to reset values immediately; next pass starts at addr 0 and must be a first pass.
- pix_num = 1: each beat is both start and end of pass; FSM stays IDLE, busy never asserts, done pulses per last-pass beat.

## Test plan
- pix_num=4, first=last=1, bias 0, shift 0, relu 0, data 10,20,-5,300 -> out 10,20,-5,127 on consecutive cycles; done with 4th output.
- pix_num=2, three passes (first: 5,6; mid: 7,8; last: 1,2), bias 4, shift 1 -> out 8,10; no outputs during first two passes.
- single pass sum -40: relu 1 -> 0; relu 0 -> -40; sum -41 shift 2 relu 0 -> -11; sum -1000 -> -128.
- out_ready low 3 cycles while in_valid high in last pass -> out_data held, in_ready 0, addr frozen, no beat lost; resumes 1/cycle.
- rst pulse (and separately clear) at addr 2 of a 4-pixel pass -> out_valid 0, busy 0; new first pass writes addr 0 and outputs correct.
- bias/shift changed mid-pass -> ignored; values latched at pass start used for all pixels.

Source files
------------

// File: rtl/conv_psum_acc.sv
// ---------------------------------------------------------------------------
// conv_psum_acc
//
// Partial-sum accumulator and requantizer sitting behind the 25-tap systolic
// convolution chain. Each accepted beat carries one full-precision result for
// the current output pixel. A pass over pix_num pixels either seeds the
// per-pixel psum buffer (first input channel), accumulates into it (middle
// channels), or, on the last channel, adds bias, optionally clamps negatives,
// arithmetic-shifts, saturates to QW bits and emits the pixel on a
// single-entry valid/ready output register.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset
//   clear_i      synchronous abort (addr 0, IDLE, output register emptied)
//   pix_num_i    pixels per pass, 1..DEPTH, stable while busy
//   bias_i       signed bias            (latched at pass start)
//   shift_i      right-shift 0..31      (latched at pass start)
//   relu_en_i    clamp negatives to 0   (latched at pass start)
//   in_valid_i   input beat valid
//   in_ready_o   input beat accepted when in_valid_i && in_ready_o
//   in_data_i    signed convolution result
//   in_first_i   pass is first input channel (latched at pass start)
//   in_last_i    pass is last input channel  (latched at pass start)
//   out_valid_o  out_data_o valid
//   out_ready_i  consumer accepts
//   out_data_o   signed quantized pixel
//   busy_o       FSM in RUN
//   done_o       one-cycle pulse with the final pixel of a last pass
// ---------------------------------------------------------------------------
module conv_psum_acc #(
  parameter int DW    = 32,
  parameter int QW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic [AW:0]          pix_num_i,
  input  logic signed [DW-1:0] bias_i,
  input  logic [4:0]           shift_i,
  input  logic                 relu_en_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [DW-1:0] in_data_i,
  input  logic                 in_first_i,
  input  logic                 in_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic signed [QW-1:0] out_data_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Saturation bounds expressed at the DW+1 bit working width.
  localparam logic signed [DW:0] QMAX = {{(DW-QW+2){1'b0}}, {(QW-1){1'b1}}};
  localparam logic signed [DW:0] QMIN = {{(DW-QW+2){1'b1}}, {(QW-1){1'b0}}};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;

  // Pass parameters captured on the first beat of a pass.
  logic                  first_q, first_d;
  logic                  last_q, last_d;
  logic                  relu_q, relu_d;
  logic [4:0]            shift_q, shift_d;
  logic signed [DW-1:0]  bias_q, bias_d;

  logic                  out_valid_q, out_valid_d;
  logic signed [QW-1:0]  out_data_q, out_data_d;
  logic                  done_q, done_d;

  // Per-pixel partial sums. Combinational read keeps the read-modify-write
  // of one pixel inside a single cycle, which matters for pix_num == 1 where
  // consecutive passes hit the same entry back to back.
  logic signed [DW-1:0]  psum_mem [DEPTH];

  // -------------------------------------------------------------------------
  // Beat datapath
  // -------------------------------------------------------------------------
  logic                  beat;
  logic                  pass_end;
  logic                  first_eff, last_eff, relu_eff;
  logic [4:0]            shift_eff;
  logic signed [DW-1:0]  bias_eff;
  logic signed [DW-1:0]  psum_rd;
  logic signed [DW-1:0]  sum;
  logic signed [DW:0]    biased;
  logic signed [DW:0]    clamped;
  logic signed [DW:0]    shifted;
  logic signed [QW-1:0]  quant;
  logic                  psum_we;

  assign in_ready_o = !out_valid_q || out_ready_i;

  // clear wins over a same-cycle beat: the beat is simply dropped.
  assign beat = in_valid_i && in_ready_o && !clear_i;

  assign pass_end = ({1'b0, addr_q} == (pix_num_i - 1'b1));

  // In IDLE the incoming beat is the pass start, so its own sideband applies
  // immediately; afterwards only the captured copies are used.
  assign first_eff = (state_q == ST_IDLE) ? in_first_i : first_q;
  assign last_eff  = (state_q == ST_IDLE) ? in_last_i  : last_q;
  assign relu_eff  = (state_q == ST_IDLE) ? relu_en_i  : relu_q;
  assign shift_eff = (state_q == ST_IDLE) ? shift_i    : shift_q;
  assign bias_eff  = (state_q == ST_IDLE) ? bias_i     : bias_q;

  assign psum_rd = psum_mem[addr_q];

  always_comb begin
    // Accumulation wraps at DW bits.
    sum = (first_eff ? '0 : psum_rd) + in_data_i;

    // Bias add is done one bit wider so it cannot overflow.
    biased = {sum[DW-1], sum} + {bias_eff[DW-1], bias_eff};

    clamped = biased;
    if (relu_eff && biased[DW]) begin
      clamped = '0;
    end

    // Arithmetic shift rounds toward minus infinity.
    shifted = clamped >>> shift_eff;

    if (shifted > QMAX) begin
      quant = QMAX[QW-1:0];
    end else if (shifted < QMIN) begin
      quant = QMIN[QW-1:0];
    end else begin
      quant = shifted[QW-1:0];
    end
  end

  assign psum_we = beat && !last_eff;

  always_ff @(posedge clk_i) begin
    if (psum_we) begin
      psum_mem[addr_q] <= sum;
    end
  end

  // -------------------------------------------------------------------------
  // Control FSM and output register, next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    first_d     = first_q;
    last_d      = last_q;
    relu_d      = relu_q;
    shift_d     = shift_q;
    bias_d      = bias_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    done_d      = 1'b0;

    if (clear_i) begin
      state_d     = ST_IDLE;
      addr_d      = '0;
      out_valid_d = 1'b0;
    end else begin
      // Consumer drains the output register unless a new pixel replaces it.
      if (out_ready_i) begin
        out_valid_d = 1'b0;
      end

      if (beat) begin
        if (state_q == ST_IDLE) begin
          first_d = in_first_i;
          last_d  = in_last_i;
          relu_d  = relu_en_i;
          shift_d = shift_i;
          bias_d  = bias_i;
        end

        if (last_eff) begin
          out_valid_d = 1'b1;
          out_data_d  = quant;
          done_d      = pass_end;
        end

        if (pass_end) begin
          // With pix_num == 1 every beat lands here and the FSM never leaves
          // IDLE.
          addr_d  = '0;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_RUN;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      relu_q      <= 1'b0;
      shift_q     <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      first_q     <= first_d;
      last_q      <= last_d;
      relu_q      <= relu_d;
      shift_q     <= shift_d;
      bias_q      <= bias_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q == ST_RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_conv_psum_acc.sv
// ---------------------------------------------------------------------------
// tb_conv_psum_acc
//
// Self-checking bench for conv_psum_acc. A behavioural model (integer
// arithmetic over a psum array) predicts the registered outputs each cycle;
// directed sequences additionally pin the model with hand-computed values,
// followed by a randomized multi-pass phase.
// ---------------------------------------------------------------------------
module tb_conv_psum_acc;

  localparam int DW    = 32;
  localparam int QW    = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clear;
  logic [AW:0]          pix_num;
  logic signed [DW-1:0] bias;
  logic [4:0]           shift;
  logic                 relu_en;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 in_first;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [QW-1:0] out_data;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  conv_psum_acc #(.DW(DW), .QW(QW), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clear_i    (clear),
    .pix_num_i  (pix_num),
    .bias_i     (bias),
    .shift_i    (shift),
    .relu_en_i  (relu_en),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_first_i (in_first),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .busy_o     (busy),
    .done_o     (done)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int  psum_m [DEPTH];
  int  m_addr;
  bit  m_run;
  bit  p_first, p_last, p_relu;
  int  p_bias, p_shift;
  bit  exp_valid, exp_done;
  int  exp_data;
  bit  last_acc;

  int  got_q[$];
  int  pass_data[$];
  int  done_cnt;
  int  stall_cnt;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int quantize(input int s, input int b, input int sh, input bit relu);
    longint t;
    longint r;
    t = longint'(s) + longint'(b);
    if (relu && t < 0) t = 0;
    r = t >>> sh;
    if (r > 127) return 127;
    if (r < -128) return -128;
    return int'(r);
  endfunction

  task automatic model_reset();
    m_addr    = 0;
    m_run     = 1'b0;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_data  = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic cycle(input bit v, input int d, input bit f, input bit l,
                       input int b, input int sh, input bit rl,
                       input bit ordy, input bit clr);
    int  s;
    bit  acc;
    bit  pend;
    chk("out_valid", longint'(out_valid), longint'(exp_valid));
    if (exp_valid) chk("out_data", longint'(out_data), longint'(exp_data));
    chk("busy", longint'(busy), longint'(m_run));
    chk("done", longint'(done), longint'(exp_done));

    in_valid  = v;
    in_data   = d;
    in_first  = f;
    in_last   = l;
    bias      = b;
    shift     = 5'(sh);
    relu_en   = rl;
    out_ready = ordy;
    clear     = clr;
    #1;
    chk("in_ready", longint'(in_ready), longint'(!exp_valid || ordy));
    if (!in_ready) stall_cnt++;
    if (out_valid && ordy) got_q.push_back(int'(out_data));
    if (done) done_cnt++;

    acc = v && (!exp_valid || ordy) && !clr;
    last_acc = acc;
    if (clr) begin
      m_addr    = 0;
      m_run     = 1'b0;
      exp_valid = 1'b0;
      exp_done  = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (acc) begin
        if (!m_run) begin
          p_first = f;
          p_last  = l;
          p_bias  = b;
          p_shift = sh;
          p_relu  = rl;
        end
        s = (p_first ? 0 : psum_m[m_addr]) + d;
        pend = (m_addr == int'(pix_num) - 1);
        if (p_last) begin
          exp_valid = 1'b1;
          exp_data  = quantize(s, p_bias, p_shift, p_relu);
          exp_done  = pend;
        end else begin
          psum_m[m_addr] = s;
          if (ordy) exp_valid = 1'b0;
        end
        m_addr = pend ? 0 : m_addr + 1;
        m_run  = !pend;
      end else if (ordy) begin
        exp_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Sends pass_data as one (possibly partial) pass with in_valid held high.
  // stall_at >= 0 drops out_ready for three cycles starting at that cycle.
  task automatic run_pass(input bit f, input bit l, input int b, input int sh,
                          input bit rl, input bit scramble, input int stall_at);
    int idx;
    int cyc;
    bit ordy;
    idx = 0;
    cyc = 0;
    while (idx < pass_data.size()) begin
      ordy = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 3);
      if (m_run && scramble)
        cycle(1'b1, pass_data[idx], 1'($urandom), 1'($urandom), int'($urandom),
              int'($urandom_range(0, 31)), 1'($urandom), ordy, 1'b0);
      else
        cycle(1'b1, pass_data[idx], f, l, b, sh, rl, ordy, 1'b0);
      if (last_acc) idx++;
      cyc++;
      if (cyc > 500) begin
        checks++;
        errors++;
        $display("FAIL run_pass_timeout: got %0d beats expected %0d", idx, pass_data.size());
        break;
      end
    end
  endtask

  task automatic drain();
    repeat (4) cycle(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_got(input string name, input int exp[$]);
    chk({name, "_count"}, longint'(got_q.size()), longint'(exp.size()));
    for (int i = 0; i < exp.size() && i < got_q.size(); i++)
      chk(name, longint'(got_q[i]), longint'(exp[i]));
  endtask

  function automatic int rnd_val();
    if ($urandom_range(0, 3) == 0) return int'($urandom);
    return int'($urandom_range(0, 4000)) - 2000;
  endfunction

  task automatic reset_checks(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_data"}, longint'(out_data), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_done"}, longint'(done), 0);
    chk({tag, "_in_ready"}, longint'(in_ready), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int np, beats, cyc, b, sh;
    bit rl, v, ordy;

    rst = 1'b1; clear = 1'b0; pix_num = 7'd4; bias = '0; shift = '0;
    relu_en = 1'b0; in_valid = 1'b0; in_data = '0; in_first = 1'b0;
    in_last = 1'b0; out_ready = 1'b1;
    done_cnt = 0; stall_cnt = 0; last_acc = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    @(negedge clk);

    // Test 1: single pass, saturation at the top
    pix_num = 7'd4;
    got_q.delete(); done_cnt = 0;
    pass_data = '{10, 20, -5, 300};
    run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    drain();
    check_got("t1_out", '{10, 20, -5, 127});
    chk("t1_done_cnt", longint'(done_cnt), 1);

    // Test 2: three channel passes, output only on the last
    pix_num = 7'd2;
    got_q.delete();
    pass_data = '{5, 6};
    run_pass(1'b1, 1'b0, 4, 1, 1'b0, 1'b0, -1);
    pass_data = '{7, 8};
    run_pass(1'b0, 1'b0, 4, 1, 1'b0, 1'b0, -1);
    chk("t2_no_early_out", longint'(got_q.size()), 0);
    pass_data = '{1, 2};
    run_pass(1'b0, 1'b1, 4, 1, 1'b0, 1'b0, -1);
    drain();
    check_got("t2_out", '{8, 10});

    // Test 3: ReLU, floor shift, negative saturation with pix_num = 1
    pix_num = 7'd1;
    got_q.delete(); done_cnt = 0;
    pass_data = '{-40};   run_pass(1'b1, 1'b1, 0, 0, 1'b1, 1'b0, -1);
    pass_data = '{-40};   run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    pass_data = '{-41};   run_pass(1'b1, 1'b1, 0, 2, 1'b0, 1'b0, -1);
    pass_data = '{-1000}; run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    drain();
    check_got("t3_out", '{0, -40, -11, -128});
    chk("t3_done_cnt", longint'(done_cnt), 4);

    // Test 4: back-pressure for three cycles in a last pass
    pix_num = 7'd4;
    got_q.delete(); stall_cnt = 0;
    pass_data = '{1, 2, 3, 4};
    run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1);
    drain();
    check_got("t4_out", '{1, 2, 3, 4});
    chk("t4_stall_cycles", longint'(stall_cnt), 3);

    // Test 5a: asynchronous reset in the middle of a pass
    pass_data = '{1, 2};
    run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    reset_checks("rst_mid");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    pass_data = '{11, 12, 13, 14};
    run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    drain();
    check_got("t5_rst_out", '{11, 12, 13, 14});

    // Test 5b: synchronous clear in the middle of a pass, with a beat offered
    pass_data = '{1, 2};
    run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    cycle(1'b1, 55, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1, 1'b1);
    chk("clear_out_valid", longint'(out_valid), 0);
    chk("clear_busy", longint'(busy), 0);
    got_q.delete();
    pass_data = '{9, 8, 7, 6};
    run_pass(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, -1);
    drain();
    check_got("t5_clr_out", '{9, 8, 7, 6});

    // Test 6: sideband scrambled after pass start must be ignored
    pix_num = 7'd3;
    got_q.delete();
    pass_data = '{4, 8, -400};
    run_pass(1'b1, 1'b1, 100, 2, 1'b0, 1'b1, -1);
    drain();
    check_got("t6_out", '{26, 27, -75});

    // Randomized multi-pass groups
    for (int g = 0; g < 16; g++) begin
      if (g % 4 == 0) pix_num = 7'd1;
      else if (g == 7) pix_num = 7'd64;
      else pix_num = 7'($urandom_range(2, 20));
      np = int'($urandom_range(1, 3));
      for (int p = 0; p < np; p++) begin
        b  = rnd_val();
        sh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                         : int'($urandom_range(0, 8));
        rl = 1'($urandom);
        beats = 0;
        cyc = 0;
        while (beats < int'(pix_num)) begin
          v    = ($urandom_range(0, 99) < 80);
          ordy = ($urandom_range(0, 99) < 75);
          if (m_run)
            cycle(v, rnd_val(), 1'($urandom), 1'($urandom), int'($urandom),
                  int'($urandom_range(0, 31)), 1'($urandom), ordy, 1'b0);
          else
            cycle(v, rnd_val(), (p == 0), (p == np - 1), b, sh, rl, ordy, 1'b0);
          if (last_acc) beats++;
          cyc++;
          if (cyc > 2000) begin
            checks++;
            errors++;
            $display("FAIL rand_timeout: got %0d beats expected %0d", beats, int'(pix_num));
            break;
          end
        end
      end
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
